// File: rtl/ppu_vram_port_if.sv
// CPU register bus plus PPU memory wrapper bus for ppu_vram_port.
// master = CPU side and memory model, slave = the port itself.
interface ppu_vram_port_if;
   logic        cpu_sel;
   logic [2:0]  cpu_reg;
   logic        cpu_rw;
   logic [7:0]  cpu_din;
   logic [7:0]  cpu_dout;
   logic        cpu_ready;
   logic        inc32;
   logic        toggle_clr;
   logic [13:0] vram_addr;
   logic [7:0]  vram_data;
   logic        vram_rw;
   logic [7:0]  vram_q;

   modport master (
      output cpu_sel, cpu_reg, cpu_rw, cpu_din,
      output inc32, toggle_clr, vram_q,
      input  cpu_dout, cpu_ready,
      input  vram_addr, vram_data, vram_rw
   );

   modport slave (
      input  cpu_sel, cpu_reg, cpu_rw, cpu_din,
      input  inc32, toggle_clr, vram_q,
      output cpu_dout, cpu_ready,
      output vram_addr, vram_data, vram_rw
   );
endinterface

// File: rtl/ppu_vram_port.sv
// PPUADDR/PPUDATA access port between the CPU bus and PPU VRAM.
// Define PPU_PALETTE_BYPASS_EN for immediate palette reads with shadow refill.
module ppu_vram_port (
   input logic            clk,
   input logic            rst,
   ppu_vram_port_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE, WR, RD_ADDR, RD_CAP, RD_SHADOW, DONE
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [13:0] v;
   logic [13:0] t;
   logic        w;
   logic [7:0]  rbuf;
   logic [7:0]  dout_q;
   logic [7:0]  wdata_q;
   logic        data_op;
   logic        shadow_op;

   logic        accept;
   logic        is_addr;
   logic        is_data;
   logic        palette;
   logic [13:0] inc;

   assign accept  = (state == IDLE) && bus.cpu_sel;
   assign is_addr = (bus.cpu_reg == 3'd6) && !bus.cpu_rw;
   assign is_data = (bus.cpu_reg == 3'd7);
   assign inc     = bus.inc32 ? 14'd32 : 14'd1;

`ifdef PPU_PALETTE_BYPASS_EN
   assign palette = (v[13:8] == 6'h3F);
`else
   assign palette = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (bus.cpu_sel) begin
               if (is_data) state_nxt = bus.cpu_rw ? RD_ADDR : WR;
               else         state_nxt = DONE;
            end
         end
         WR:        state_nxt = DONE;
         RD_ADDR:   state_nxt = RD_CAP;
         RD_CAP:    state_nxt = palette ? RD_SHADOW : DONE;
         RD_SHADOW: state_nxt = DONE;
         DONE:      state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.vram_addr = v;
      bus.vram_rw   = 1'b0;
      bus.cpu_ready = 1'b0;
      unique case (1'b1)
         state == WR:        bus.vram_rw   = 1'b1;
         state == RD_SHADOW: bus.vram_addr = v & 14'h2FFF;
         state == DONE:      bus.cpu_ready = 1'b1;
         default: ;
      endcase
   end

   assign bus.vram_data = wdata_q;
   assign bus.cpu_dout  = dout_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         v         <= 14'd0;
         t         <= 14'd0;
         w         <= 1'b0;
         rbuf      <= 8'd0;
         dout_q    <= 8'd0;
         wdata_q   <= 8'd0;
         data_op   <= 1'b0;
         shadow_op <= 1'b0;
      end else begin
         if (accept) begin
            data_op   <= is_data;
            shadow_op <= 1'b0;
            if (is_data && !bus.cpu_rw)
               wdata_q <= bus.cpu_din;
            if (is_addr) begin
               if (!w) begin
                  t[13:8] <= bus.cpu_din[5:0];
               end else begin
                  t[7:0] <= bus.cpu_din;
                  v      <= {t[13:8], bus.cpu_din};
               end
            end
         end
         // a coincident status read clears w after the write used it
         if (bus.toggle_clr)
            w <= 1'b0;
         else if (accept && is_addr)
            w <= ~w;
         if (state == RD_CAP) begin
            if (palette) begin
               dout_q <= bus.vram_q;
            end else begin
               dout_q <= rbuf;
               rbuf   <= bus.vram_q;
            end
         end
         if (state == RD_SHADOW)
            shadow_op <= 1'b1;
         if (state == DONE) begin
            if (data_op)   v    <= v + inc;
            if (shadow_op) rbuf <= bus.vram_q;
         end
      end
   end
endmodule
